// File: rtl/keypad_scan_4x4.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_4x4
// Description : 4x4 matrix keypad scanner. Drives one-hot columns, samples
//               synchronized rows into a frame image, and debounces a single
//               key per frame into a one-hot d vector with a level enable and
//               a one-cycle acceptance pulse. No rollover.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_4x4 #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] d,
  output logic        en,
  output logic        press
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_MAX  = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } state_t;

  state_t           state;
  logic [3:0]       row_s1;
  logic [3:0]       row_s2;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [15:0]      frame_img;
  logic [3:0]       cand;
  logic [3:0]       cnt;
  logic [3:0]       cnt_inc;
  logic             slot_end;
  logic             frame_end;
  logic [15:0]      frame_now;
  logic [4:0]       bit_cnt;
  logic [3:0]       hit_idx;
  logic             single;
  logic             cand_hit;

  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (col_idx == 2'd3);
  assign cnt_inc   = cnt + 4'd1;
  assign single    = (bit_cnt == 5'd1);
  assign cand_hit  = frame_now[cand];

  // Frame image as it stands this cycle, with the current column's rows merged in
  always_comb begin
    frame_now = frame_img;
    for (int r = 0; r < 4; r++) begin
      frame_now[{2'(r), col_idx}] = row_s2[r];
    end
  end

  // Classify the frame: number of keys seen and the index of the (last) one found
  always_comb begin
    bit_cnt = '0;
    hit_idx = '0;
    for (int k = 0; k < 16; k++) begin
      if (frame_now[k]) begin
        bit_cnt = bit_cnt + 5'd1;
        hit_idx = 4'(k);
      end
    end
  end

  // Row synchronizer, column rotation and per-slot sampling into the frame image
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1    <= '0;
      row_s2    <= '0;
      div_cnt   <= '0;
      col_idx   <= '0;
      col       <= 4'b0001;
      frame_img <= '0;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
      if (slot_end) begin
        div_cnt   <= '0;
        col_idx   <= col_idx + 2'd1;
        col       <= {col[2:0], col[3]};
        frame_img <= frame_now;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Debounce FSM, stepped once per frame; d/en/press are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
      d     <= '0;
      en    <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (single) begin
              cand <= hit_idx;
              cnt  <= 4'd1;
              if (DEB_MAX == 4'd1) begin
                state <= HELD;
                d     <= 16'd1 << hit_idx;
                en    <= 1'b1;
                press <= 1'b1;
              end else begin
                state <= DEB;
              end
            end
          end
          DEB: begin
            if (single && (hit_idx == cand)) begin
              cnt <= cnt_inc;
              if (cnt_inc == DEB_MAX) begin
                state <= HELD;
                d     <= 16'd1 << cand;
                en    <= 1'b1;
                press <= 1'b1;
              end
            end else if (single) begin
              // A different lone key restarts the debounce on that key
              cand <= hit_idx;
              cnt  <= 4'd1;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          HELD: begin
            if (!cand_hit) begin
              if (DEB_MAX == 4'd1) begin
                state <= IDLE;
                cnt   <= '0;
                d     <= '0;
                en    <= 1'b0;
              end else begin
                state <= REL;
                cnt   <= 4'd1;
              end
            end
          end
          REL: begin
            if (cand_hit) begin
              // Bounce during release: back to held without a new pulse
              state <= HELD;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == DEB_MAX) begin
                state <= IDLE;
                cnt   <= '0;
                d     <= '0;
                en    <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
